param_memory: RTL and testbench

Parametrised single-port synchronous scratch memory: the multi-word, multi-bit successor of the team's one-cell memory. It stores DEPTH words of WIDTH bits and keeps the read_sig/write_sig command pair. It adds addressing, a post-reset clear sequence, a registered read-valid strobe, and explicit flagging of illegal commands. It sits beside datapath blocks as local storage and is driven by a controller FSM.

---
 rtl/param_memory_if.sv | 42 ++++
 rtl/param_memory.sv | 154 +++++++++++++++
 tb/tb_param_memory.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/param_memory_if.sv
// -----------------------------------------------------------------------------
// param_memory_if
// Command/data bundle between a controlling FSM (master) and param_memory
// (slave).
//
// Signals
//   read_sig   master->slave  read request
//   write_sig  master->slave  write request
//   addr       master->slave  word address, AW = $clog2(DEPTH) bits
//   dataIn     master->slave  write data, WIDTH bits
//   dataOut    slave->master  registered read data, WIDTH bits
//   out_valid  slave->master  one-cycle strobe, dataOut updated by a read
//   busy       slave->master  clear sweep in progress, commands ignored
//   cfg_err    slave->master  one-cycle strobe, illegal command rejected
//   err_count  slave->master  saturating illegal-command count (8 bits)
// -----------------------------------------------------------------------------
interface param_memory_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic             read_sig;
   logic             write_sig;
   logic [AW-1:0]    addr;
   logic [WIDTH-1:0] dataIn;
   logic [WIDTH-1:0] dataOut;
   logic             out_valid;
   logic             busy;
   logic             cfg_err;
   logic [7:0]       err_count;

   modport master (
      output read_sig, write_sig, addr, dataIn,
      input  dataOut, out_valid, busy, cfg_err, err_count
   );

   modport slave (
      input  read_sig, write_sig, addr, dataIn,
      output dataOut, out_valid, busy, cfg_err, err_count
   );
endinterface

// File: rtl/param_memory.sv
// -----------------------------------------------------------------------------
// param_memory
// Parametrised single-port synchronous scratch memory with a post-reset clear
// sweep, registered read data with a valid strobe, and illegal-command flagging.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset (restarts the clear sweep)
//   bus   param_memory_if.slave: read_sig, write_sig, addr, dataIn in;
//         dataOut, out_valid, busy, cfg_err, err_count out
//
// Parameters
//   WIDTH  data word width in bits (>= 1)
//   DEPTH  number of words (>= 2, any value)
//
// Build option
//   PARAM_MEMORY_ERR_COUNT_EN  when defined, err_count is an 8-bit saturating
//   count of illegal commands; otherwise err_count is tied to 0.
// -----------------------------------------------------------------------------
module param_memory #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 16
) (
   input logic           clk,
   input logic           rst,
   param_memory_if.slave bus
);
   localparam int            AW        = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [AW-1:0]    r_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_data_out;
   logic             r_out_valid;
   logic             r_cfg_err;

   logic             w_oob;
   logic             w_mem_we;
   logic [AW-1:0]    w_waddr;
   logic [WIDTH-1:0] w_wdata;
   logic             w_rd;
   logic             w_illegal;

   // Out-of-range addresses only exist when DEPTH is not a power of two.
   generate
      if (DEPTH == (1 << AW)) begin : g_pow2
         assign w_oob = 1'b0;
      end else begin : g_npow2
         assign w_oob = (bus.addr > LAST_ADDR);
      end
   endgenerate

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_INIT;
      else     r_state <= w_state_nxt;
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_mem_we    = 1'b0;
      w_waddr     = bus.addr;
      w_wdata     = bus.dataIn;
      w_rd        = 1'b0;
      w_illegal   = 1'b0;

      case (r_state)
         ST_INIT: begin
            // Clear sweep: one zero word per cycle, commands ignored.
            w_mem_we = 1'b1;
            w_waddr  = r_ptr;
            w_wdata  = '0;
            if (r_ptr == LAST_ADDR) w_state_nxt = ST_READY;
         end
         ST_READY: begin
            if (bus.read_sig || bus.write_sig) begin
               if ((bus.read_sig && bus.write_sig) || w_oob) w_illegal = 1'b1;
               else if (bus.write_sig)                       w_mem_we  = 1'b1;
               else                                          w_rd      = 1'b1;
            end
         end
         default: w_state_nxt = ST_INIT;
      endcase

      // Reset aborts whatever the current cycle would have done.
      if (rst) begin
         w_state_nxt = ST_INIT;
         w_mem_we    = 1'b0;
         w_rd        = 1'b0;
         w_illegal   = 1'b0;
      end
   end

   // Sweep pointer, restarted from 0 on every reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (r_state == ST_INIT) begin
         r_ptr <= (r_ptr == LAST_ADDR) ? '0 : r_ptr + 1'b1;
      end
   end

   // NOTE: the array has no reset branch; the clear sweep zeroes it, which
   // keeps it mappable onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_waddr] <= w_wdata;
   end

   // Registered read data and strobes. An illegal command forces dataOut to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_out  <= '0;
         r_out_valid <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_out_valid <= w_rd;
         r_cfg_err   <= w_illegal;
         if (w_rd)           r_data_out <= r_mem[bus.addr];
         else if (w_illegal) r_data_out <= '0;
      end
   end

`ifdef PARAM_MEMORY_ERR_COUNT_EN
   logic [7:0] r_err_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_count <= 8'd0;
      end else if (w_illegal && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   assign bus.err_count = r_err_count;
`else
   assign bus.err_count = 8'd0;
`endif

   assign bus.dataOut   = r_data_out;
   assign bus.out_valid = r_out_valid;
   assign bus.cfg_err   = r_cfg_err;
   assign bus.busy      = (r_state == ST_INIT);

endmodule

// File: tb/tb_param_memory.sv
// -----------------------------------------------------------------------------
// tb_param_memory
// Directed bench for param_memory: a DEPTH=16 instance for reset, clear,
// read/write, illegal-command, saturation and mid-operation reset scenarios,
// and a DEPTH=10 instance for out-of-range addressing. Both WIDTH=4.
// err_count expectations follow PARAM_MEMORY_ERR_COUNT_EN.
// -----------------------------------------------------------------------------
module tb_param_memory;
`ifdef PARAM_MEMORY_ERR_COUNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_checks;
   int   n_errors;

   always #5 clk = ~clk;

   param_memory_if #(.WIDTH(4), .DEPTH(16)) bus16 ();
   param_memory_if #(.WIDTH(4), .DEPTH(10)) bus10 ();

   param_memory #(.WIDTH(4), .DEPTH(16)) u_mem16 (.clk(clk), .rst(rst), .bus(bus16));
   param_memory #(.WIDTH(4), .DEPTH(10)) u_mem10 (.clk(clk), .rst(rst), .bus(bus10));

   // Advance one rising edge and sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive16(input logic rd, input logic wr, input logic [3:0] a, input logic [3:0] d);
      bus16.read_sig  = rd;
      bus16.write_sig = wr;
      bus16.addr      = a;
      bus16.dataIn    = d;
   endtask

   task automatic drive10(input logic rd, input logic wr, input logic [3:0] a, input logic [3:0] d);
      bus10.read_sig  = rd;
      bus10.write_sig = wr;
      bus10.addr      = a;
      bus10.dataIn    = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      n_checks++; if (bus16.busy !== 1'b1) begin n_errors++; $display("FAIL rst_busy: got %b exp 1", bus16.busy); end
      n_checks++; if (bus16.dataOut !== 4'h0) begin n_errors++; $display("FAIL rst_dataOut: got %h exp 0", bus16.dataOut); end
      n_checks++; if (bus16.out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid: got %b exp 0", bus16.out_valid); end
      n_checks++; if (bus16.cfg_err !== 1'b0) begin n_errors++; $display("FAIL rst_cfg_err: got %b exp 0", bus16.cfg_err); end
      n_checks++; if (bus16.err_count !== 8'd0) begin n_errors++; $display("FAIL rst_err_count: got %0d exp 0", bus16.err_count); end
      rst = 1'b0;
      // busy falls exactly DEPTH edges after the first edge with rst=0.
      for (int i = 1; i <= 16; i++) begin
         step();
         n_checks++; if (bus16.busy !== (i < 16)) begin n_errors++; $display("FAIL sweep16_busy edge %0d: got %b exp %b", i, bus16.busy, (i < 16)); end
         n_checks++; if (bus10.busy !== (i < 10)) begin n_errors++; $display("FAIL sweep10_busy edge %0d: got %b exp %b", i, bus10.busy, (i < 10)); end
      end
   endtask

   task automatic test_clear_reads();
      for (int i = 0; i < 16; i++) begin
         drive16(1'b1, 1'b0, i[3:0], 4'h0);
         step();
         n_checks++; if (bus16.dataOut !== 4'h0) begin n_errors++; $display("FAIL clear_data addr %0d: got %h exp 0", i, bus16.dataOut); end
         n_checks++; if (bus16.out_valid !== 1'b1) begin n_errors++; $display("FAIL clear_valid addr %0d: got %b exp 1", i, bus16.out_valid); end
      end
      drive16(1'b0, 1'b0, 4'h0, 4'h0);
      step();
      n_checks++; if (bus16.out_valid !== 1'b0) begin n_errors++; $display("FAIL clear_valid_drop: got %b exp 0", bus16.out_valid); end
   endtask

   task automatic test_write_read();
      drive16(1'b0, 1'b1, 4'd3, 4'hA);
      step();
      n_checks++; if (bus16.out_valid !== 1'b0) begin n_errors++; $display("FAIL wr_no_valid: got %b exp 0", bus16.out_valid); end
      n_checks++; if (bus16.dataOut !== 4'h0) begin n_errors++; $display("FAIL wr_data_hold: got %h exp 0", bus16.dataOut); end
      drive16(1'b1, 1'b0, 4'd3, 4'h0);
      step();
      n_checks++; if (bus16.dataOut !== 4'hA) begin n_errors++; $display("FAIL rd3_data: got %h exp a", bus16.dataOut); end
      n_checks++; if (bus16.out_valid !== 1'b1) begin n_errors++; $display("FAIL rd3_valid: got %b exp 1", bus16.out_valid); end
      drive16(1'b1, 1'b0, 4'd2, 4'h0);
      step();
      n_checks++; if (bus16.dataOut !== 4'h0) begin n_errors++; $display("FAIL rd2_data: got %h exp 0", bus16.dataOut); end
      drive16(1'b1, 1'b0, 4'd4, 4'h0);
      step();
      n_checks++; if (bus16.dataOut !== 4'h0) begin n_errors++; $display("FAIL rd4_data: got %h exp 0", bus16.dataOut); end
      n_checks++; if (bus16.out_valid !== 1'b1) begin n_errors++; $display("FAIL rd4_valid: got %b exp 1", bus16.out_valid); end
      drive16(1'b0, 1'b0, 4'd0, 4'h0);
      step();
      n_checks++; if (bus16.dataOut !== 4'h0 || bus16.out_valid !== 1'b0) begin n_errors++; $display("FAIL idle_hold: got %h/%b exp 0/0", bus16.dataOut, bus16.out_valid); end
   endtask

   task automatic test_illegal();
      drive16(1'b0, 1'b1, 4'd7, 4'h5);
      step();
      drive16(1'b1, 1'b0, 4'd7, 4'h0);
      step();
      n_checks++; if (bus16.dataOut !== 4'h5) begin n_errors++; $display("FAIL rd7_pre: got %h exp 5", bus16.dataOut); end
      drive16(1'b1, 1'b1, 4'd7, 4'hF);
      step();
      n_checks++; if (bus16.cfg_err !== 1'b1) begin n_errors++; $display("FAIL ill_cfg_err: got %b exp 1", bus16.cfg_err); end
      n_checks++; if (bus16.dataOut !== 4'h0) begin n_errors++; $display("FAIL ill_dataOut: got %h exp 0", bus16.dataOut); end
      n_checks++; if (bus16.out_valid !== 1'b0) begin n_errors++; $display("FAIL ill_out_valid: got %b exp 0", bus16.out_valid); end
      drive16(1'b0, 1'b0, 4'd0, 4'h0);
      step();
      n_checks++; if (bus16.cfg_err !== 1'b0) begin n_errors++; $display("FAIL ill_pulse_end: got %b exp 0", bus16.cfg_err); end
      n_checks++; if (bus16.err_count !== (ERR_EN ? 8'd1 : 8'd0)) begin n_errors++; $display("FAIL ill_err_count: got %0d exp %0d", bus16.err_count, (ERR_EN ? 1 : 0)); end
      drive16(1'b1, 1'b0, 4'd7, 4'h0);
      step();
      n_checks++; if (bus16.dataOut !== 4'h5) begin n_errors++; $display("FAIL rd7_post: got %h exp 5", bus16.dataOut); end
      // Two illegal commands in a row keep cfg_err high.
      drive16(1'b1, 1'b1, 4'd1, 4'h3);
      step();
      n_checks++; if (bus16.cfg_err !== 1'b1) begin n_errors++; $display("FAIL ill_b2b_1: got %b exp 1", bus16.cfg_err); end
      step();
      n_checks++; if (bus16.cfg_err !== 1'b1) begin n_errors++; $display("FAIL ill_b2b_2: got %b exp 1", bus16.cfg_err); end
      drive16(1'b0, 1'b0, 4'd0, 4'h0);
      step();
      n_checks++; if (bus16.err_count !== (ERR_EN ? 8'd3 : 8'd0)) begin n_errors++; $display("FAIL ill_b2b_count: got %0d exp %0d", bus16.err_count, (ERR_EN ? 3 : 0)); end
      drive16(1'b1, 1'b0, 4'd1, 4'h0);
      step();
      n_checks++; if (bus16.dataOut !== 4'h0) begin n_errors++; $display("FAIL rd1_unwritten: got %h exp 0", bus16.dataOut); end
      drive16(1'b0, 1'b0, 4'd0, 4'h0);
   endtask

   task automatic test_out_of_range();
      drive10(1'b0, 1'b1, 4'd2, 4'h6);
      step();
      n_checks++; if (bus10.cfg_err !== 1'b0) begin n_errors++; $display("FAIL oor_legal_wr: got %b exp 0", bus10.cfg_err); end
      drive10(1'b0, 1'b1, 4'd12, 4'hF);
      step();
      n_checks++; if (bus10.cfg_err !== 1'b1) begin n_errors++; $display("FAIL oor_wr_cfg_err: got %b exp 1", bus10.cfg_err); end
      n_checks++; if (bus10.out_valid !== 1'b0) begin n_errors++; $display("FAIL oor_wr_valid: got %b exp 0", bus10.out_valid); end
      drive10(1'b1, 1'b0, 4'd2, 4'h0);
      step();
      n_checks++; if (bus10.dataOut !== 4'h6 || bus10.cfg_err !== 1'b0) begin n_errors++; $display("FAIL oor_rd2: got %h/%b exp 6/0", bus10.dataOut, bus10.cfg_err); end
      drive10(1'b1, 1'b0, 4'd12, 4'h0);
      step();
      n_checks++; if (bus10.cfg_err !== 1'b1) begin n_errors++; $display("FAIL oor_rd_cfg_err: got %b exp 1", bus10.cfg_err); end
      n_checks++; if (bus10.out_valid !== 1'b0) begin n_errors++; $display("FAIL oor_rd_valid: got %b exp 0", bus10.out_valid); end
      n_checks++; if (bus10.dataOut !== 4'h0) begin n_errors++; $display("FAIL oor_rd_data: got %h exp 0", bus10.dataOut); end
      // Last legal address, then the first illegal one.
      drive10(1'b1, 1'b0, 4'd9, 4'h0);
      step();
      n_checks++; if (bus10.out_valid !== 1'b1 || bus10.cfg_err !== 1'b0) begin n_errors++; $display("FAIL oor_rd9: got valid %b err %b exp 1/0", bus10.out_valid, bus10.cfg_err); end
      drive10(1'b1, 1'b0, 4'd10, 4'h0);
      step();
      n_checks++; if (bus10.cfg_err !== 1'b1 || bus10.out_valid !== 1'b0) begin n_errors++; $display("FAIL oor_rd10: got err %b valid %b exp 1/0", bus10.cfg_err, bus10.out_valid); end
      n_checks++; if (bus10.err_count !== (ERR_EN ? 8'd3 : 8'd0)) begin n_errors++; $display("FAIL oor_err_count: got %0d exp %0d", bus10.err_count, (ERR_EN ? 3 : 0)); end
      // No word changed except the legal write to addr 2.
      for (int i = 0; i < 10; i++) begin
         drive10(1'b1, 1'b0, i[3:0], 4'h0);
         step();
         n_checks++; if (bus10.dataOut !== ((i == 2) ? 4'h6 : 4'h0)) begin n_errors++; $display("FAIL oor_scan addr %0d: got %h exp %h", i, bus10.dataOut, ((i == 2) ? 4'h6 : 4'h0)); end
      end
      drive10(1'b0, 1'b0, 4'd0, 4'h0);
   endtask

   task automatic test_saturation();
      drive16(1'b1, 1'b1, 4'd0, 4'h0);
      repeat (300) step();
      n_checks++; if (bus16.cfg_err !== 1'b1) begin n_errors++; $display("FAIL sat_cfg_err: got %b exp 1", bus16.cfg_err); end
      n_checks++; if (bus16.err_count !== (ERR_EN ? 8'd255 : 8'd0)) begin n_errors++; $display("FAIL sat_err_count: got %0d exp %0d", bus16.err_count, (ERR_EN ? 255 : 0)); end
      drive16(1'b0, 1'b0, 4'd0, 4'h0);
      step();
   endtask

   task automatic test_reset_mid();
      drive16(1'b0, 1'b1, 4'd5, 4'h9);
      step();
      drive16(1'b1, 1'b0, 4'd5, 4'h0);
      step();
      n_checks++; if (bus16.dataOut !== 4'h9 || bus16.out_valid !== 1'b1) begin n_errors++; $display("FAIL mid_rd5: got %h/%b exp 9/1", bus16.dataOut, bus16.out_valid); end
      drive16(1'b1, 1'b0, 4'd3, 4'h0);
      step();
      n_checks++; if (bus16.dataOut !== 4'hA) begin n_errors++; $display("FAIL mid_rd3: got %h exp a", bus16.dataOut); end
      rst = 1'b1;
      step();
      n_checks++; if (bus16.out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_rst_valid: got %b exp 0", bus16.out_valid); end
      n_checks++; if (bus16.busy !== 1'b1) begin n_errors++; $display("FAIL mid_rst_busy: got %b exp 1", bus16.busy); end
      n_checks++; if (bus16.dataOut !== 4'h0 || bus16.err_count !== 8'd0) begin n_errors++; $display("FAIL mid_rst_regs: got %h/%0d exp 0/0", bus16.dataOut, bus16.err_count); end
      rst = 1'b0;
      // Commands during the sweep must be ignored.
      for (int i = 1; i <= 16; i++) begin
         case (i % 3)
            0:       drive16(1'b0, 1'b1, 4'd5, 4'hF);
            1:       drive16(1'b1, 1'b0, 4'd3, 4'h0);
            default: drive16(1'b1, 1'b1, 4'd5, 4'h7);
         endcase
         step();
         n_checks++; if (bus16.busy !== (i < 16)) begin n_errors++; $display("FAIL mid_sweep_busy edge %0d: got %b exp %b", i, bus16.busy, (i < 16)); end
         n_checks++; if (bus16.out_valid !== 1'b0 || bus16.cfg_err !== 1'b0) begin n_errors++; $display("FAIL mid_sweep_ignored edge %0d: got valid %b err %b exp 0/0", i, bus16.out_valid, bus16.cfg_err); end
      end
      for (int i = 0; i < 16; i++) begin
         drive16(1'b1, 1'b0, i[3:0], 4'h0);
         step();
         n_checks++; if (bus16.dataOut !== 4'h0 || bus16.out_valid !== 1'b1) begin n_errors++; $display("FAIL mid_scan addr %0d: got %h/%b exp 0/1", i, bus16.dataOut, bus16.out_valid); end
      end
      drive16(1'b0, 1'b0, 4'd0, 4'h0);
      step();
      n_checks++; if (bus16.err_count !== 8'd0) begin n_errors++; $display("FAIL mid_err_count: got %0d exp 0", bus16.err_count); end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      drive16(1'b0, 1'b0, 4'd0, 4'h0);
      drive10(1'b0, 1'b0, 4'd0, 4'h0);
      test_reset();
      test_clear_reads();
      test_write_read();
      test_illegal();
      test_out_of_range();
      test_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
